// File: rtl/cmd_stage_feeder.sv
// -----------------------------------------------------------------------------
// cmd_stage_feeder
//
// Streams a two-stage command program from a command store into a command
// queue. The decomposition stage covers store addresses [0, decomp) and the
// recomposition stage covers [decomp, total). Between the stages, and at the
// end, the feeder waits until the queue is empty and the top reports that all
// issued work has retired.
//
// Read path: at most one store read is outstanding, and its word lands in a
// single holding register that drives o_data. If a word arrives while the
// holding register is still occupied by a word the full queue refused, the
// arriving word is discarded and its address is read again. This keeps the
// queue sequence exact under any full pattern while still sustaining one
// write per cycle when the queue accepts every word.
//
// Optional feature: define CMD_FEEDER_CYCLE_CNT_EN to build the per-stage
// cycle counters. Without it, both counter outputs are tied to zero.
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_start          one-cycle pulse, accepted only in IDLE or DONE
//   i_decomp_count   decomposition command count (sampled on accepted start)
//   i_total_count    total command count (sampled on accepted start)
//   o_rom_addr       command store read address
//   o_rom_rd         command store read strobe
//   i_rom_data       command store data, valid the cycle after o_rom_rd
//   o_write          command queue write strobe
//   o_data           command queue write word
//   i_fifo_full      command queue full
//   i_fifo_empty     command queue empty
//   i_finished_task  all issued work retired
//   o_stage          0 idle, 1 decomp, 2 recomp, 3 done
//   o_busy           run in progress
//   o_done           run complete, held until next start or reset
//   o_decomp_cycles  cycles spent in the decomposition stage
//   o_recomp_cycles  cycles spent in the recomposition stage
// -----------------------------------------------------------------------------
module cmd_stage_feeder #(
    parameter int CMD_W  = 64,
    parameter int ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_decomp_count,
    input  logic [ADDR_W-1:0] i_total_count,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_rd,
    input  logic [CMD_W-1:0]  i_rom_data,
    output logic              o_write,
    output logic [CMD_W-1:0]  o_data,
    input  logic              i_fifo_full,
    input  logic              i_fifo_empty,
    input  logic              i_finished_task,
    output logic [1:0]        o_stage,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_decomp_cycles,
    output logic [31:0]       o_recomp_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED_D,
        S_WAIT_D,
        S_FEED_R,
        S_WAIT_R,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_dec;        // clamped decomp count
    logic [ADDR_W-1:0]   r_tot;
    logic [ADDR_W-1:0]   r_rd_ptr;     // next address to read
    logic [ADDR_W-1:0]   r_wr_ptr;     // address of the next word to write
    logic                r_pend;       // read issued last cycle, data arrives now
    logic                r_hold_vld;
    logic [CMD_W-1:0]    r_hold_data;
    logic                r_wait_armed; // past the first cycle of a WAIT state

    logic                w_feeding;
    logic                w_in_wait;
    logic [ADDR_W-1:0]   w_end;
    logic                w_write;
    logic                w_room;
    logic                w_drop;
    logic                w_issue;
    logic                w_last_wr;
    logic                w_release;
    logic                w_start_ok;
    logic [ADDR_W-1:0]   w_dec_clamp;

    assign w_feeding   = (r_state == S_FEED_D) || (r_state == S_FEED_R);
    assign w_in_wait   = (r_state == S_WAIT_D) || (r_state == S_WAIT_R);
    assign w_end       = (r_state == S_FEED_R) ? r_tot : r_dec;
    assign w_write     = w_feeding && r_hold_vld && !i_fifo_full;
    // The arriving word fits if the holding register is empty or drains now.
    assign w_room      = !r_hold_vld || w_write;
    assign w_drop      = r_pend && !w_room;
    assign w_issue     = w_feeding && (r_rd_ptr < w_end) && !w_drop;
    assign w_last_wr   = w_write && (r_wr_ptr == (w_end - ONE));
    assign w_release   = r_wait_armed && i_fifo_empty && i_finished_task;
    assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dec_clamp = (i_decomp_count > i_total_count) ? i_total_count
                                                          : i_decomp_count;

    assign o_write    = w_write;
    assign o_rom_rd   = w_issue;
    assign o_rom_addr = r_rd_ptr;
    assign o_data     = r_hold_data;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_stage      = 2'd0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = (w_dec_clamp == '0) ? S_WAIT_D : S_FEED_D;
                end
            end
            S_FEED_D: begin
                o_stage = 2'd1;
                o_busy  = 1'b1;
                if (w_last_wr) begin
                    w_state_next = S_WAIT_D;
                end
            end
            S_WAIT_D: begin
                o_stage = 2'd1;
                o_busy  = 1'b1;
                if (w_release) begin
                    w_state_next = (r_dec == r_tot) ? S_WAIT_R : S_FEED_R;
                end
            end
            S_FEED_R: begin
                o_stage = 2'd2;
                o_busy  = 1'b1;
                if (w_last_wr) begin
                    w_state_next = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                o_stage = 2'd2;
                o_busy  = 1'b1;
                if (w_release) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_stage = 2'd3;
                o_done  = 1'b1;
                if (w_start_ok) begin
                    w_state_next = (w_dec_clamp == '0) ? S_WAIT_D : S_FEED_D;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read pointer, holding register and run parameters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dec        <= '0;
            r_tot        <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_pend       <= 1'b0;
            r_hold_vld   <= 1'b0;
            r_hold_data  <= '0;
            r_wait_armed <= 1'b0;
        end else if (w_start_ok) begin
            r_dec        <= w_dec_clamp;
            r_tot        <= i_total_count;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_pend       <= 1'b0;
            r_hold_vld   <= 1'b0;
            r_wait_armed <= 1'b0;
        end else begin
            r_pend       <= w_issue;
            r_wait_armed <= w_in_wait && (w_state_next == r_state);
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end else if (w_drop) begin
                // Only one read is ever outstanding, so the discarded word
                // is always the one just below the read pointer.
                r_rd_ptr <= r_rd_ptr - ONE;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (r_pend && w_room) begin
                r_hold_data <= i_rom_data;
                r_hold_vld  <= 1'b1;
            end else if (w_write) begin
                r_hold_vld  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-stage cycle counters
    // ------------------------------------------------------------------
`ifdef CMD_FEEDER_CYCLE_CNT_EN
    logic [31:0] r_dcyc;
    logic [31:0] r_rcyc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dcyc <= '0;
            r_rcyc <= '0;
        end else if (w_start_ok) begin
            r_dcyc <= '0;
            r_rcyc <= '0;
        end else begin
            if (((r_state == S_FEED_D) || (r_state == S_WAIT_D)) &&
                (r_dcyc != 32'hFFFF_FFFF)) begin
                r_dcyc <= r_dcyc + 32'd1;
            end
            if (((r_state == S_FEED_R) || (r_state == S_WAIT_R)) &&
                (r_rcyc != 32'hFFFF_FFFF)) begin
                r_rcyc <= r_rcyc + 32'd1;
            end
        end
    end

    assign o_decomp_cycles = r_dcyc;
    assign o_recomp_cycles = r_rcyc;
`else
    assign o_decomp_cycles = 32'd0;
    assign o_recomp_cycles = 32'd0;
`endif

endmodule
